// File: rtl/a0_uart_pkg.sv
// a0_uart_pkg
//   Shared types and constants for the a0 UART streamer and related
//   peripherals: transmitter state encoding, UART frame data width and
//   the line idle level.
package a0_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/a0_uart_streamer_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, first-word-fall-through (popData shows the head
//   whenever the FIFO is non-empty).
//   Ports:
//     clk, rst        clock, async active-high reset (clears pointers/count)
//     push, pushData  write request and data
//     pop             read request; advances the head
//     popData         current head word
//     full, empty     occupancy flags
//     count           words currently stored, 0..DEPTH
//   A push while full is accepted only if a pop happens in the same cycle;
//   a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic             wrEn, rdEn;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdEn    = pop && !empty;
  // the slot freed by a same-cycle pop can take the incoming word
  assign wrEn    = push && (!full || rdEn);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
      case ({wrEn, rdEn})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/a0_uart_streamer.sv
// a0_uart_streamer
//   Watches the core's a0 register, queues every new value and sends it
//   over an 8N1 UART line, most-significant byte first, each byte LSB first.
//   Ports:
//     clk, rst     system clock, async active-high reset
//     a0           core result register
//     enable       capture enable (changes seen while low are not replayed)
//     tx           UART serial output, idles high (registered)
//     busy         transmitter not idle (registered)
//     overflow     sticky: a change was dropped because the FIFO was full
//     fifo_count   words currently queued
module a0_uart_streamer
  import a0_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         a0,
  input  logic                          enable,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NBYTES = DATA_WIDTH / UART_DATA_BITS;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IW     = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

  logic [DATA_WIDTH-1:0]     a0Q;
  logic                      pushReq, pop;
  logic                      fifoFull, fifoEmpty;
  logic [DATA_WIDTH-1:0]     fifoHead;

  uart_state_t               state, stateNxt;
  logic [CW-1:0]             cnt, cntNxt;
  logic [IW-1:0]             bitIdx, bitIdxNxt;
  logic [BW-1:0]             byteIdx, byteIdxNxt;
  logic [DATA_WIDTH-1:0]     wordSr, wordSrNxt;
  logic                      txNxt;
  logic [UART_DATA_BITS-1:0] curByte;
  logic                      periodEnd;

  // change detector: a0Q tracks a0 even while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) a0Q <= '0;
    else     a0Q <= a0;
  end

  assign pushReq = enable && (a0 != a0Q);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushReq),
    .pushData (a0),
    .pop      (pop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifo_count)
  );

  // a push while full is only lost when no pop frees a slot that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overflow <= 1'b0;
    else if (pushReq && fifoFull && !pop) overflow <= 1'b1;
  end

  assign curByte   = wordSr[DATA_WIDTH-1 -: UART_DATA_BITS];
  assign periodEnd = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bitIdx  <= '0;
      byteIdx <= '0;
      wordSr  <= '0;
      tx      <= UART_IDLE_LEVEL;
      busy    <= 1'b0;
    end else begin
      state   <= stateNxt;
      cnt     <= cntNxt;
      bitIdx  <= bitIdxNxt;
      byteIdx <= byteIdxNxt;
      wordSr  <= wordSrNxt;
      tx      <= txNxt;
      busy    <= (stateNxt != IDLE);
    end
  end

  // tx is registered from the next-state decision, so the line changes on
  // the same edge the state does
  always_comb begin
    stateNxt   = state;
    cntNxt     = cnt;
    bitIdxNxt  = bitIdx;
    byteIdxNxt = byteIdx;
    wordSrNxt  = wordSr;
    txNxt      = tx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        txNxt = UART_IDLE_LEVEL;
        if (!fifoEmpty) begin
          pop        = 1'b1;
          wordSrNxt  = fifoHead;
          byteIdxNxt = '0;
          cntNxt     = '0;
          stateNxt   = START;
          txNxt      = 1'b0;
        end
      end
      START: begin
        if (periodEnd) begin
          cntNxt    = '0;
          bitIdxNxt = '0;
          stateNxt  = DATA;
          txNxt     = curByte[0];
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (periodEnd) begin
          cntNxt = '0;
          if (bitIdx == LAST_BIT) begin
            stateNxt = STOP;
            txNxt    = UART_IDLE_LEVEL;
          end else begin
            bitIdxNxt = bitIdx + 1'b1;
            txNxt     = curByte[bitIdxNxt];
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (periodEnd) begin
          cntNxt = '0;
          if (byteIdx < LAST_BYTE) begin
            byteIdxNxt = byteIdx + 1'b1;
            wordSrNxt  = wordSr << UART_DATA_BITS;
            stateNxt   = START;
            txNxt      = 1'b0;
          end else if (!fifoEmpty) begin
            // next word starts straight after this stop bit, no idle gap
            pop        = 1'b1;
            wordSrNxt  = fifoHead;
            byteIdxNxt = '0;
            stateNxt   = START;
            txNxt      = 1'b0;
          end else begin
            stateNxt = IDLE;
            txNxt    = UART_IDLE_LEVEL;
          end
        end else begin
          cntNxt = cnt + 1'b1;
        end
      end
      default: begin
        stateNxt = IDLE;
        txNxt    = UART_IDLE_LEVEL;
      end
    endcase
  end

endmodule
